// File: rtl/arm_mc_control.sv
// Multicycle ARM control: main sequencing FSM, ALU decode, NZCV flag register
// and condition evaluation, with stalls on the memory ready handshake.
module arm_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC <= PC+4 when memory ready
  // DECODE | read registers, latch condition result for this instruction
  // MEMADR | compute load/store address
  // MEMRD  | read data memory until ready
  // MEMWB  | write loaded data to Rd
  // MEMWR  | write data memory until ready (skipped if not executed)
  // EXECR  | ALU op, register operand; optional flag update
  // EXECI  | ALU op, immediate operand; optional flag update
  // ALUWB  | write ALU result to Rd, or to PC when Rd is R15
  // BRANCH | PC <= PC+8+offset
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic        cond_ex_l;
  logic        cond_ex;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [1:0]  alu_ctrl;
  logic [1:0]  flag_w;
  logic        pc_write, ir_write, mem_write, reg_write;
  logic        unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  always_comb begin
    alu_ctrl = 2'b00;
    flag_w   = 2'b00;
    case (funct[4:1])
      4'b0100: begin alu_ctrl = 2'b00; flag_w = {funct[0], funct[0]}; end
      4'b0010: begin alu_ctrl = 2'b01; flag_w = {funct[0], funct[0]}; end
      4'b0000: begin alu_ctrl = 2'b10; flag_w = {funct[0], 1'b0};     end
      4'b1100: begin alu_ctrl = 2'b11; flag_w = {funct[0], 1'b0};     end
      default: begin alu_ctrl = 2'b00; flag_w = 2'b00;                end
    endcase
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~(c & ~z);
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_l <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        cond_ex_l <= cond_ex;
      // Condition was latched in DECODE, so this update cannot gate its own writeback.
      if ((state_q == EXECR || state_q == EXECI) && cond_ex_l) begin
        if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_write  = MemReady;
        state_d   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = cond_ex_l;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = cond_ex_l;
        state_d   = (!cond_ex_l || MemReady) ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUControl = alu_ctrl;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctrl;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_write = cond_ex_l & (rd != 4'hF);
        pc_write  = cond_ex_l & (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = cond_ex_l;
      end
      default: state_d = FETCH;
    endcase
  end

  assign PCWrite  = pc_write  & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign Flags    = flags_q;
  assign State    = state_q;

endmodule

// File: tb/tb_arm_mc_control.sv
// Scoreboard bench for arm_mc_control: directed instruction sequences push
// per-cycle expectations; a negedge monitor pops and compares.
module tb_arm_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  Flags, State;

  arm_mc_control dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegSrc(RegSrc),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  // we  = {PCWrite, IRWrite, MemWrite, RegWrite}
  // sel = {ImmSrc, RegSrc, AdrSrc, ResultSrc, ALUControl, ALUSrcA, ALUSrcB}
  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  we;
    logic [3:0]  fl;
    logic [11:0] sel;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (State !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, State, e.st);
      end
      checks++;
      if ({PCWrite, IRWrite, MemWrite, RegWrite} !== e.we) begin
        errors++;
        $display("FAIL write_en cyc=%0d got=%b exp=%b", cyc,
                 {PCWrite, IRWrite, MemWrite, RegWrite}, e.we);
      end
      checks++;
      if (Flags !== e.fl) begin
        errors++;
        $display("FAIL flags cyc=%0d got=%b exp=%b", cyc, Flags, e.fl);
      end
      checks++;
      if ({ImmSrc, RegSrc, AdrSrc, ResultSrc, ALUControl, ALUSrcA, ALUSrcB} !== e.sel) begin
        errors++;
        $display("FAIL selects cyc=%0d got=%h exp=%h", cyc,
                 {ImmSrc, RegSrc, AdrSrc, ResultSrc, ALUControl, ALUSrcA, ALUSrcB}, e.sel);
      end
    end
  end

  task automatic step(input logic rst, input logic [19:0] ins, input logic [3:0] af,
                      input logic mr, input logic [3:0] st, input logic [3:0] we,
                      input logic [3:0] fl, input logic [11:0] sel);
    exp_t x;
    reset = rst; Instr = ins; ALUFlags = af; MemReady = mr;
    x.st = st; x.we = we; x.fl = fl; x.sel = sel;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; Instr = 20'hE2802; ALUFlags = 4'h0; MemReady = 1'b1;
    @(posedge clk); #1;
    step(1, 20'hE2802, 4'h0, 1, 4'd0, 4'b0000, 4'h0, 12'h046);

    // ADD R2,R0,#5
    step(0, 20'hE2802, 4'h0, 1, 4'd0, 4'b1100, 4'h0, 12'h046);
    step(0, 20'hE2802, 4'h0, 1, 4'd1, 4'b0000, 4'h0, 12'h046);
    step(0, 20'hE2802, 4'hF, 1, 4'd7, 4'b0000, 4'h0, 12'h001);
    step(0, 20'hE2802, 4'h0, 1, 4'd8, 4'b0001, 4'h0, 12'h000);

    // LDR with 3-cycle memory stall
    step(0, 20'hE5902, 4'h0, 1, 4'd0, 4'b1100, 4'h0, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd1, 4'b0000, 4'h0, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd2, 4'b0000, 4'h0, 12'h601);
    for (int i = 0; i < 3; i++)
      step(0, 20'hE5902, 4'h0, 0, 4'd3, 4'b0000, 4'h0, 12'h680);
    step(0, 20'hE5902, 4'h0, 1, 4'd3, 4'b0000, 4'h0, 12'h680);
    step(0, 20'hE5902, 4'h0, 1, 4'd4, 4'b0001, 4'h0, 12'h620);

    // STR
    step(0, 20'hE5802, 4'h0, 1, 4'd0, 4'b1100, 4'h0, 12'h646);
    step(0, 20'hE5802, 4'h0, 1, 4'd1, 4'b0000, 4'h0, 12'h646);
    step(0, 20'hE5802, 4'h0, 1, 4'd2, 4'b0000, 4'h0, 12'h601);
    step(0, 20'hE5802, 4'h0, 1, 4'd5, 4'b0010, 4'h0, 12'h680);

    // SUBS R3,R0,R0 with Z result
    step(0, 20'hE0503, 4'h0, 1, 4'd0, 4'b1100, 4'h0, 12'h046);
    step(0, 20'hE0503, 4'h0, 1, 4'd1, 4'b0000, 4'h0, 12'h046);
    step(0, 20'hE0503, 4'h4, 1, 4'd6, 4'b0000, 4'h0, 12'h008);
    step(0, 20'hE0503, 4'h0, 1, 4'd8, 4'b0001, 4'h4, 12'h000);

    // ADDNE: not executed while Z=1
    step(0, 20'h12802, 4'h0, 1, 4'd0, 4'b1100, 4'h4, 12'h046);
    step(0, 20'h12802, 4'h0, 1, 4'd1, 4'b0000, 4'h4, 12'h046);
    step(0, 20'h12802, 4'hB, 1, 4'd7, 4'b0000, 4'h4, 12'h001);
    step(0, 20'h12802, 4'h0, 1, 4'd8, 4'b0000, 4'h4, 12'h000);

    // BEQ taken
    step(0, 20'h0A000, 4'h0, 1, 4'd0, 4'b1100, 4'h4, 12'h946);
    step(0, 20'h0A000, 4'h0, 1, 4'd1, 4'b0000, 4'h4, 12'h946);
    step(0, 20'h0A000, 4'h0, 1, 4'd9, 4'b1000, 4'h4, 12'h941);

    // ADD R15,R0,#4: result goes to PC, not the register file
    step(0, 20'hE280F, 4'h0, 1, 4'd0, 4'b1100, 4'h4, 12'h046);
    step(0, 20'hE280F, 4'h0, 1, 4'd1, 4'b0000, 4'h4, 12'h046);
    step(0, 20'hE280F, 4'h0, 1, 4'd7, 4'b0000, 4'h4, 12'h001);
    step(0, 20'hE280F, 4'h0, 1, 4'd8, 4'b1000, 4'h4, 12'h000);

    // Fetch stall, then Op=11 treated as NOP
    for (int i = 0; i < 4; i++)
      step(0, 20'hEC000, 4'h0, 0, 4'd0, 4'b0000, 4'h4, 12'hC46);
    step(0, 20'hEC000, 4'h0, 1, 4'd0, 4'b1100, 4'h4, 12'hC46);
    step(0, 20'hEC000, 4'h0, 1, 4'd1, 4'b0000, 4'h4, 12'hC46);

    // ORRS R1,R0,#1: only N and Z update
    step(0, 20'hE3901, 4'h0, 1, 4'd0, 4'b1100, 4'h4, 12'h046);
    step(0, 20'hE3901, 4'h0, 1, 4'd1, 4'b0000, 4'h4, 12'h046);
    step(0, 20'hE3901, 4'hF, 1, 4'd7, 4'b0000, 4'h4, 12'h019);
    step(0, 20'hE3901, 4'h0, 1, 4'd8, 4'b0001, 4'hC, 12'h000);

    // SUBS with Cond=1111: no write, no flag update
    step(0, 20'hF0503, 4'h0, 1, 4'd0, 4'b1100, 4'hC, 12'h046);
    step(0, 20'hF0503, 4'h0, 1, 4'd1, 4'b0000, 4'hC, 12'h046);
    step(0, 20'hF0503, 4'hA, 1, 4'd6, 4'b0000, 4'hC, 12'h008);
    step(0, 20'hF0503, 4'h0, 1, 4'd8, 4'b0000, 4'hC, 12'h000);

    // LDR interrupted by reset while stalled in MEMRD
    step(0, 20'hE5902, 4'h0, 1, 4'd0, 4'b1100, 4'hC, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd1, 4'b0000, 4'hC, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd2, 4'b0000, 4'hC, 12'h601);
    step(0, 20'hE5902, 4'h0, 0, 4'd3, 4'b0000, 4'hC, 12'h680);
    step(1, 20'hE5902, 4'h0, 1, 4'd0, 4'b0000, 4'h0, 12'h646);
    step(1, 20'hE5902, 4'h0, 1, 4'd0, 4'b0000, 4'h0, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd0, 4'b1100, 4'h0, 12'h646);
    step(0, 20'hE5902, 4'h0, 1, 4'd1, 4'b0000, 4'h0, 12'h646);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
